// File: rtl/int_sqrt_pipe.sv
// Pipelined floor(sqrt(a)): one root bit resolved per stage, MSB first.
// Restoring digit-by-digit algorithm; one operand in, one result out per clock.
module int_sqrt_pipe #(
  parameter int WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic [WIDTH-1:0]         a,
  output logic                     valid_out,
  output logic [(WIDTH+1)/2-1:0]   root
);

  localparam int RW   = (WIDTH + 1) / 2;
  localparam int LAT  = RW;
  localparam int AW   = 2 * RW;
  localparam int REMW = RW + 2;
  localparam int TW   = RW + 4;

  logic            vld_q [LAT];
  logic            vld_d [LAT];
  logic [AW-1:0]   rad_q [LAT];
  logic [AW-1:0]   rad_d [LAT];
  logic [REMW-1:0] rem_q [LAT];
  logic [REMW-1:0] rem_d [LAT];
  logic [RW-1:0]   rt_q  [LAT];
  logic [RW-1:0]   rt_d  [LAT];

  logic            valid_q, valid_d;
  logic [RW-1:0]   root_q, root_d;
  logic [TW-1:0]   trial, sub;

  always_comb begin
    vld_d   = vld_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    rt_d    = rt_q;
    trial   = '0;
    sub     = '0;
    valid_d = 1'b0;
    root_d  = root_q;

    // Rank 0 only captures the operand; odd widths gain a zero MSB here.
    vld_d[0] = valid_in;
    rad_d[0] = AW'(a);
    rem_d[0] = '0;
    rt_d[0]  = '0;

    for (int i = 1; i < LAT; i++) begin
      trial    = {rem_q[i-1], rad_q[i-1][AW-1 -: 2]};
      sub      = TW'({rt_q[i-1], 2'b01});
      vld_d[i] = vld_q[i-1];
      rad_d[i] = rad_q[i-1] << 2;
      if (trial >= sub) begin
        rem_d[i] = REMW'(trial - sub);
        rt_d[i]  = RW'({rt_q[i-1], 1'b1});
      end else begin
        rem_d[i] = REMW'(trial);
        rt_d[i]  = RW'({rt_q[i-1], 1'b0});
      end
    end

    // Last bit resolves straight into the output register.
    trial   = {rem_q[LAT-1], rad_q[LAT-1][AW-1 -: 2]};
    sub     = TW'({rt_q[LAT-1], 2'b01});
    valid_d = vld_q[LAT-1];
    if (vld_q[LAT-1]) begin
      root_d = RW'({rt_q[LAT-1], trial >= sub});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        vld_q[i] <= 1'b0;
        rad_q[i] <= '0;
        rem_q[i] <= '0;
        rt_q[i]  <= '0;
      end
      valid_q <= 1'b0;
      root_q  <= '0;
    end else begin
      vld_q   <= vld_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      rt_q    <= rt_d;
      valid_q <= valid_d;
      root_q  <= root_d;
    end
  end

  assign valid_out = valid_q;
  assign root      = root_q;

endmodule

// File: tb/tb_int_sqrt_pipe.sv
// Directed and random checks of int_sqrt_pipe against a
// reference floor(sqrt) and an LAT-deep valid/root delay line.
module tb_int_sqrt_pipe;

  localparam int W   = 20;
  localparam int RW  = 10;
  localparam int LAT = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [W-1:0]  a;
  logic          valid_out;
  logic [RW-1:0] root;

  int checks = 0;
  int errors = 0;

  logic          pv [LAT];
  int            pr [LAT];
  logic          ev;
  int            er;

  int_sqrt_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .a         (a),
    .valid_out (valid_out),
    .root      (root)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pr[i] = 0;
    end
    ev = 1'b0;
    er = 0;
  endtask

  // Drive one cycle, then compare outputs 1ns after the edge.
  task automatic step(input logic v, input logic [W-1:0] av);
    valid_in = v;
    a        = av;
    @(posedge clk);
    #1;
    ev = pv[LAT-1];
    if (ev) er = pr[LAT-1];
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pr[i] = pr[i-1];
    end
    pv[0] = v;
    pr[0] = isqrt(int'(av));
    chk("valid_out", 32'(valid_out), 32'(ev));
    chk("root", 32'(root), 32'(er));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom));
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    a        = '0;
    model_clear();
    #1;
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_root", 32'(root), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Small operands with gaps
    step(1'b1, 20'd0);   idle(3);
    step(1'b1, 20'd1);   idle(2);
    step(1'b1, 20'd16);  idle(4);
    step(1'b1, 20'd15);  idle(1);
    step(1'b1, 20'd144); idle(5);
    step(1'b1, 20'd143);
    idle(LAT + 2);
    chk("root_143", 32'(root), 32'd11);

    // Boundaries
    step(1'b1, 20'd1048575);
    step(1'b1, 20'd1046529);
    step(1'b1, 20'd1046528);
    idle(LAT + 1);
    chk("root_1022", 32'(root), 32'd1022);

    // Back-to-back stream, no bubbles
    for (int i = 100; i < 132; i++) step(1'b1, W'(i));
    idle(LAT + 1);

    // Random stream with gaps
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      step(1'b1, W'($urandom));
    end
    idle(LAT + 1);

    // Hold: one result then random a with valid_in low
    step(1'b1, 20'd49);
    idle(LAT);
    chk("hold_49", 32'(root), 32'd7);
    idle(30);
    chk("hold_end", 32'(root), 32'd7);

    // Mid-cycle asynchronous reset with results in flight
    step(1'b1, 20'd900);
    idle(4);
    for (int i = 0; i < 5; i++) step(1'b1, W'(200 + i * 37));
    idle(3);
    #3;
    reset = 1'b1;
    #1;
    chk("async_valid", 32'(valid_out), 32'd0);
    chk("async_root", 32'(root), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    idle(LAT + 5);
    step(1'b1, 20'd400);
    idle(LAT - 1);
    chk("pre_400_valid", 32'(valid_out), 32'd0);
    step(1'b0, 20'd0);
    chk("post_rst_valid", 32'(valid_out), 32'd1);
    chk("post_rst_root", 32'(root), 32'd20);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
